// File: rtl/fcore_result_writeback_arbiter_if.sv
// fcore_result_writeback_arbiter_if: execution-unit result streams in, register-file write stream out
interface fcore_result_writeback_arbiter_if #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 32,
    parameter int USER_WIDTH = 32
);
    localparam int SRC_WIDTH = $clog2(N_INPUTS);
    logic [N_INPUTS-1:0]            in_valid;
    logic [N_INPUTS-1:0]            in_ready;
    logic [N_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [N_INPUTS*DEST_WIDTH-1:0] in_dest;
    logic [N_INPUTS*USER_WIDTH-1:0] in_user;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [DEST_WIDTH-1:0]          out_dest;
    logic [USER_WIDTH-1:0]          out_user;
    logic [SRC_WIDTH-1:0]           out_source;
    logic [15:0]                    collision_count;
    modport master (
        output in_valid, in_data, in_dest, in_user, out_ready,
        input  in_ready, out_valid, out_data, out_dest, out_user, out_source, collision_count
    );
    modport slave (
        input  in_valid, in_data, in_dest, in_user, out_ready,
        output in_ready, out_valid, out_data, out_dest, out_user, out_source, collision_count
    );
endinterface

// File: rtl/fcore_result_writeback_arbiter.sv
// fcore_result_writeback_arbiter: per-unit result FIFOs drained round-robin into one registered write port
module fcore_result_writeback_arbiter #(
    parameter int N_INPUTS   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 32,
    parameter int USER_WIDTH = 32
) (
    input logic clock,
    input logic reset,
    fcore_result_writeback_arbiter_if.slave bus
);
    localparam int SW = $clog2(N_INPUTS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + DEST_WIDTH + USER_WIDTH;

    logic [N_INPUTS-1:0] non_empty;
    logic [N_INPUTS-1:0] push;
    logic [N_INPUTS-1:0] pop;
    logic [EW-1:0]       heads [N_INPUTS];
    logic [SW-1:0]       rr_ptr;
    logic [SW-1:0]       grant;
    logic [SW-1:0]       scan_idx;
    logic                found;
    logic                load_en;

    assign load_en = !bus.out_valid || bus.out_ready;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_fifo
        logic [EW-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0] rd_ptr;
        logic [PW-1:0] wr_ptr;
        logic [PW:0]   count;
        // Readiness reflects only the pre-edge occupancy, so a full FIFO never accepts even while popping.
        assign bus.in_ready[i] = count < (PW+1)'(FIFO_DEPTH);
        assign non_empty[i]    = count != '0;
        assign push[i]         = bus.in_valid[i] && bus.in_ready[i];
        assign pop[i]          = load_en && found && grant == SW'(i);
        assign heads[i]        = mem[rd_ptr];
        always_ff @(posedge clock) begin
            if (push[i])
                mem[wr_ptr] <= {bus.in_data[i*DATA_WIDTH +: DATA_WIDTH],
                                bus.in_dest[i*DEST_WIDTH +: DEST_WIDTH],
                                bus.in_user[i*USER_WIDTH +: USER_WIDTH]};
        end
        always_ff @(posedge clock) begin
            if (!reset) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[i]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[i]) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
            end
        end
    end

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 1; k <= N_INPUTS; k++) begin
            scan_idx = SW'((int'(rr_ptr) + k) % N_INPUTS);
            if (!found && non_empty[scan_idx]) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.out_valid       <= 1'b0;
            bus.out_data        <= '0;
            bus.out_dest        <= '0;
            bus.out_user        <= '0;
            bus.out_source      <= '0;
            bus.collision_count <= '0;
            rr_ptr              <= SW'(N_INPUTS - 1);
        end else begin
            if (load_en) begin
                bus.out_valid                            <= found;
                {bus.out_data, bus.out_dest, bus.out_user} <= found ? heads[grant] : '0;
                bus.out_source                           <= found ? grant : '0;
                if (found) rr_ptr <= grant;
            end
            if ($countones(non_empty) > 1 && bus.collision_count != 16'hFFFF)
                bus.collision_count <= bus.collision_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_fcore_result_writeback_arbiter.sv
// tb_fcore_result_writeback_arbiter: random and directed traffic scored against a queue-based round-robin model
module tb_fcore_result_writeback_arbiter;
    localparam int N = 4;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fcore_result_writeback_arbiter_if #(.N_INPUTS(N), .DATA_WIDTH(32), .DEST_WIDTH(32), .USER_WIDTH(32)) bus();

    fcore_result_writeback_arbiter #(
        .N_INPUTS(N), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(32), .DEST_WIDTH(32), .USER_WIDTH(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] t;
        logic [31:0] u;
        logic [1:0]  s;
    } ent_t;

    ent_t q [N][$];
    ent_t exp_q [$];
    ent_t cur;
    int   ptr = N - 1;
    bit   mv = 1'b0;
    int   coll = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   armed = 1'b0;
    bit   last_v = 1'b0;
    bit   single = 1'b0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Drive one cycle of stimulus, check the visible state, then advance the model across the coming edge.
    task automatic step(input logic [N-1:0] v, input logic r, input logic rn);
        logic [N-1:0] rdy;
        bit   hit;
        int   ne;
        int   j;
        bus.in_valid  = v;
        bus.out_ready = r;
        reset         = rn;
        for (int i = 0; i < N; i++) begin
            bus.in_data[i*32 +: 32] = $urandom;
            bus.in_dest[i*32 +: 32] = $urandom;
            bus.in_user[i*32 +: 32] = $urandom;
        end
        if (single) begin
            bus.in_data[64 +: 32] = 32'h0000_00A5;
            bus.in_dest[64 +: 32] = 32'd7;
            bus.in_user[64 +: 32] = 32'h11;
        end
        if (armed) begin
            for (int i = 0; i < N; i++) chk($sformatf("in_ready%0d", i), 64'(bus.in_ready[i]), 64'(q[i].size() < DEPTH));
            chk("collision_count", 64'(bus.collision_count), 64'(coll));
        end
        if (!rn) begin
            for (int i = 0; i < N; i++) q[i].delete();
            exp_q.delete();
            ptr   = N - 1;
            mv    = 1'b0;
            coll  = 0;
            armed = 1'b1;
        end else begin
            ne = 0;
            for (int i = 0; i < N; i++) begin
                ne += (q[i].size() != 0) ? 1 : 0;
                rdy[i] = q[i].size() < DEPTH;
            end
            if (ne >= 2 && coll < 16'hFFFF) coll++;
            if (!mv || r) begin
                hit = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    j = (ptr + k) % N;
                    if (!hit && q[j].size() != 0) begin
                        hit = 1'b1;
                        exp_q.push_back(q[j].pop_front());
                        ptr = j;
                    end
                end
                mv = hit;
            end
            for (int i = 0; i < N; i++)
                if (v[i] && rdy[i])
                    q[i].push_back('{bus.in_data[i*32 +: 32], bus.in_dest[i*32 +: 32], bus.in_user[i*32 +: 32], 2'(i)});
        end
        @(negedge clock);
    endtask

    initial begin
        ent_t e;
        forever begin
            @(posedge clock);
            #1;
            if (armed) begin
                if (!reset) begin
                    chk("reset_valid", 64'(bus.out_valid), 64'd0);
                    chk("reset_fields", 64'(|{bus.out_data, bus.out_dest, bus.out_user, bus.out_source}), 64'd0);
                end else if (!last_v || bus.out_ready) begin
                    if (bus.out_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_output", 64'(bus.out_valid), 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_data", 64'(bus.out_data), 64'(e.d));
                            chk("out_dest", 64'(bus.out_dest), 64'(e.t));
                            chk("out_user", 64'(bus.out_user), 64'(e.u));
                            chk("out_source", 64'(bus.out_source), 64'(e.s));
                            cur = e;
                        end
                    end else begin
                        chk("idle_fields", 64'(|{bus.out_data, bus.out_dest, bus.out_user, bus.out_source}), 64'd0);
                        chk("missing_output", 64'(exp_q.size()), 64'd0);
                    end
                end else begin
                    chk("hold_valid", 64'(bus.out_valid), 64'd1);
                    chk("hold_data", 64'(bus.out_data), 64'(cur.d));
                    chk("hold_dest", 64'(bus.out_dest), 64'(cur.t));
                    chk("hold_source", 64'(bus.out_source), 64'(cur.s));
                end
                last_v = bus.out_valid;
            end
        end
    end

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_dest   = '0;
        bus.in_user   = '0;
        bus.out_ready = 1'b0;
        @(negedge clock);
        repeat (2) step(4'b0000, 1'b1, 1'b0);
        single = 1'b1;
        step(4'b0100, 1'b1, 1'b1);
        single = 1'b0;
        step(4'b0000, 1'b1, 1'b1);
        chk("single_valid", 64'(bus.out_valid), 64'd1);
        chk("single_data", 64'(bus.out_data), 64'hA5);
        chk("single_dest", 64'(bus.out_dest), 64'd7);
        chk("single_user", 64'(bus.out_user), 64'h11);
        chk("single_source", 64'(bus.out_source), 64'd2);
        step(4'b0000, 1'b1, 1'b1);
        chk("single_idle", 64'(bus.out_valid), 64'd0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1011, 1'b1, 1'b1);
        repeat (4) step(4'b0000, 1'b1, 1'b1);
        chk("simul_collisions", 64'(bus.collision_count), 64'd2);
        step(4'b0000, 1'b1, 1'b0);
        repeat (5) step(4'b0010, 1'b0, 1'b1);
        chk("full_ready", 64'(bus.in_ready[1]), 64'd0);
        step(4'b0000, 1'b1, 1'b1);
        chk("ready_after_pop", 64'(bus.in_ready[1]), 64'd1);
        repeat (6) step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b0);
        repeat (24) step(4'b1111, 1'b1, 1'b1);
        repeat (20) step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b0);
        repeat (5) step(4'b0001, 1'b0, 1'b1);
        repeat (8) step(4'b0000, 1'b1, 1'b1);
        repeat (4) step(4'b0100, 1'b0, 1'b1);
        chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        step(4'b0000, 1'b0, 1'b0);
        chk("mid_reset_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_reset_ready", 64'(bus.in_ready), 64'hF);
        chk("mid_reset_coll", 64'(bus.collision_count), 64'd0);
        repeat (5) step(4'b0000, 1'b1, 1'b1);
        repeat (600) step(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
        repeat (30) step(4'b0000, 1'b1, 1'b1);
        chk("drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
